// File: rtl/uart_rx_if.sv
// Signal bundle for the uart_rx receiver: serial input plus received-byte outputs.
// The master modport is the receiver. The slave modport is the line driver and byte consumer.
interface uart_rx_if;
  logic       UART_RX;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  UART_RX,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output UART_RX,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err strobes.
// A stop bit sampled low parks the receiver in StBreak until the line returns high.
module uart_rx #(
  parameter int unsigned CLK_RATE_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic  clk,
  input  logic  reset,
  uart_rx_if.master bus
);
  localparam int unsigned CPB  = CLK_RATE_HZ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CntW = $clog2(CPB);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StStop, StBreak} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      sync1_q <= bus.UART_RX;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // A start bit still low at its midpoint is genuine; anything else is a glitch.
        if (cnt_q == CntW'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? StIdle : StBit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBit: begin
        if (cnt_q == CntW'(CPB - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync2_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        // Leaving mid stop bit lets an immediately following start edge be caught.
        if (cnt_q == CntW'(CPB - 1)) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (sync2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and randomised 8N1 frames scored against
// expected strobe cycles and bytes computed from frame timing arithmetic.
module tb_uart_rx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD_R = 10_000;
  localparam int CPB    = CLK_HZ / BAUD_R;
  localparam int HALF   = CPB / 2;
  // Pin change to strobe: 2 synchroniser flops, 1 idle detect edge, then half a bit and 9 bits.
  localparam int LAT    = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   both_cnt = 0;
  int   rise_cyc = -1;
  int   fall_cyc = -1;
  bit   busy_prev = 1'b0;

  typedef struct {
    int         cyc;
    bit         fe;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  uart_rx_if bus ();

  uart_rx #(
    .CLK_RATE_HZ(CLK_HZ),
    .BAUD       (BAUD_R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid || bus.frame_err) evq.push_back('{cyc: cyc, fe: bus.frame_err, d: bus.data});
    if (bus.valid && bus.frame_err) both_cnt++;
    if (busy_prev && !bus.busy) fall_cyc = cyc;
    if (!busy_prev && bus.busy) rise_cyc = cyc;
    busy_prev = bus.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; bit j ends pct% of the nominal (j+1)*CPB cycles after the start edge.
  // abort_bit >= 0 pulses reset at the start of that bit and releases the line.
  task automatic send(input logic [7:0] b, input bit stop, input int pct, input int abort_bit,
                      output int s);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    s  = cyc;
    for (int j = 0; j < 10; j++) begin
      if (j == abort_bit) begin
        bus.UART_RX = 1'b1;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        return;
      end
      bus.UART_RX = fr[j];
      while ((cyc - s) < ((j + 1) * CPB * pct) / 100) idle(1);
    end
  endtask

  task automatic expect_byte(input string tag, input int s, input logic [7:0] b);
    check({tag, "_count"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      check({tag, "_cycle"}, evq[0].cyc, s + LAT);
      check({tag, "_ferr"}, evq[0].fe, 0);
      check({tag, "_data"}, evq[0].d, b);
    end
    evq.delete();
  endtask

  initial begin
    int s, s1, s2, s3;
    logic [7:0] rb;
    int pct;

    reset = 1'b1;
    bus.UART_RX = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("rst_data", bus.data, 8'h00);
    check("rst_valid", bus.valid, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);

    // Plain byte, exact timing and busy edges.
    send(8'hA5, 1'b1, 100, -1, s);
    idle(20);
    check("a5_busy_rise", rise_cyc, s + 3);
    check("a5_busy_fall", fall_cyc, s + LAT);
    expect_byte("a5", s, 8'hA5);

    // Short low glitch: start aborts at its midpoint without a strobe.
    s = cyc;
    bus.UART_RX = 1'b0;
    idle(40);
    bus.UART_RX = 1'b1;
    idle(100);
    check("gl_busy_rise", rise_cyc, s + 3);
    check("gl_busy_fall", fall_cyc, s + 3 + HALF);
    check("gl_events", evq.size(), 0);
    send(8'h3C, 1'b1, 100, -1, s);
    idle(20);
    expect_byte("gl_3c", s, 8'h3C);

    // Bad stop bit followed by a long break.
    send(8'h00, 1'b0, 100, -1, s);
    idle(20 * CPB);
    bus.UART_RX = 1'b1;
    idle(30);
    check("brk_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      check("brk_cycle", evq[0].cyc, s + LAT);
      check("brk_fe", evq[0].fe, 1);
    end
    evq.delete();
    check("brk_data_hold", bus.data, 8'h3C);
    check("brk_busy", bus.busy, 0);
    send(8'h3C, 1'b1, 100, -1, s);
    idle(20);
    expect_byte("brk_3c", s, 8'h3C);

    // Back-to-back frames with no idle gap.
    send(8'h01, 1'b1, 100, -1, s1);
    send(8'hFF, 1'b1, 100, -1, s2);
    send(8'h80, 1'b1, 100, -1, s3);
    idle(20);
    check("b2b_count", evq.size(), 3);
    if (evq.size() >= 3) begin
      check("b2b_c0", evq[0].cyc, s1 + LAT);
      check("b2b_gap1", evq[1].cyc - evq[0].cyc, 10 * CPB);
      check("b2b_gap2", evq[2].cyc - evq[1].cyc, 10 * CPB);
      check("b2b_d0", evq[0].d, 8'h01);
      check("b2b_d1", evq[1].d, 8'hFF);
      check("b2b_d2", evq[2].d, 8'h80);
    end
    evq.delete();

    // Reset during bit 3 aborts the frame and clears data.
    send(8'h5A, 1'b1, 100, 4, s);
    idle(12 * CPB);
    check("rst_mid_events", evq.size(), 0);
    check("rst_mid_data", bus.data, 8'h00);
    check("rst_mid_busy", bus.busy, 0);
    send(8'h5A, 1'b1, 100, -1, s);
    idle(20);
    expect_byte("rst_5a", s, 8'h5A);

    // Baud mismatch of +/-3%.
    send(8'hC3, 1'b1, 103, -1, s);
    idle(20);
    expect_byte("slow_c3", s, 8'hC3);
    send(8'hC3, 1'b1, 97, -1, s);
    idle(20);
    expect_byte("fast_c3", s, 8'hC3);

    // Random bytes, small rate skew and random idle gaps.
    for (int i = 0; i < 4; i++) begin
      rb  = 8'($urandom);
      pct = 98 + int'($urandom_range(0, 4));
      idle(int'($urandom_range(0, 30)));
      send(rb, 1'b1, pct, -1, s);
      idle(10);
      expect_byte($sformatf("rnd%0d", i), s, rb);
    end

    check("never_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- Sits on the breakout host/debug serial link; receive counterpart of the existing UART transmitter, same clock domain and baud derivation.
- Synchronises the asynchronous RX pin, samples mid-bit, and emits each received byte with a one-cycle valid strobe. Framing errors are flagged separately.

Parameters:
- CLK_RATE_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- Derived: CPB = CLK_RATE_HZ / BAUD (integer divide, 434 at defaults); HALF = CPB / 2 (217).
- Counter width is $clog2(CPB).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- UART_RX  in  1  asynchronous serial input; idle high.
- data  out  8  last correctly received byte; holds until the next good byte.
- valid  out  1  one-cycle strobe: data updated this cycle.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, any state): state=IDLE, counter=0, bit index=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, both synchroniser flops=1.
- Synchroniser: 2 flops on UART_RX; rx_s = second flop. No other logic uses UART_RX directly.
- valid and frame_err default to 0 every cycle; they are never high together.
- IDLE: when rx_s==0, go to START with counter=0.
- START:
  - Count up; at counter==HALF-1, check rx_s.
  - rx_s==0: go to BIT with counter=0, index=0.
  - rx_s==1: glitch; return to IDLE with no strobe.
- BIT:
  - Count to CPB-1. At that count, shift[index] <= rx_s and counter=0.
  - index 0..6: index+1. index 7: go to STOP.
- STOP:
  - Count to CPB-1, then sample rx_s.
  - rx_s==1: data <= shift, valid=1 next cycle, go to IDLE.
  - rx_s==0: frame_err=1 next cycle, data unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frame_err and never a spurious byte.
- Timing: let t0 be the first IDLE cycle with rx_s==0.
  - Bit k (0..7) is sampled at t0+HALF+(k+1)*CPB.
  - Stop bit is sampled at t0+HALF+9*CPB.
  - valid/frame_err is high at t0+HALF+9*CPB+1 (4124 cycles at defaults).
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge immediately after the stop bit is detected. No minimum idle gap is required.
- Sampling is mid-bit, giving roughly ±4% accumulated baud-mismatch tolerance over the frame.
- Reset mid-frame aborts the frame: no strobe, data returns to 0. Reception restarts on the next falling edge after the synchroniser refills (2 cycles).

Test Plan:
- Send byte 0xA5 with a correct stop bit at BAUD -> exactly one valid pulse at t0+4124 with data=0xA5; frame_err never high; busy falls in the same cycle valid rises.
- Low glitch of 100 cycles on an idle line -> START aborts at HALF; no valid, no frame_err; busy high about 217 cycles, then IDLE; a following 0x3C is received correctly.
- Byte 0x00 with stop bit driven low, line held low for 20 bit times, then high, then 0x3C -> one frame_err pulse, data stays at its prior value, no valid during the break; then valid with data=0x3C.
- Back-to-back 0x01, 0xFF, 0x80 with zero idle between frames -> three valid pulses spaced 10*CPB cycles apart, data 0x01, 0xFF, 0x80 in order.
- Assert reset for 1 cycle during bit 3 of 0x5A -> data=0, no strobe for that frame; the next full 0x5A frame gives valid with data=0x5A.
- Transmit 0xC3 with bit period CPB*1.03, then CPB*0.97 -> both received as 0xC3 with no frame_err.
